// File: rtl/fp_sqrt_unit.sv
// Iterative restoring square root: {exp, sig} radicand in, {0, exp, root} out, one root bit per cycle.
// Optional macro SQRT_ROUND_EN rounds the root to nearest (saturating) instead of truncating.
module fp_sqrt_unit #(
  parameter int IN_EXP_W  = 9,
  parameter int IN_SIG_W  = 30,
  parameter int OUT_EXP_W = 8,
  parameter int OUT_SIG_W = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_EXP_W+IN_SIG_W-1:0]     in_word,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_EXP_W+OUT_SIG_W:0]     out_word,
  output logic                             out_inexact
);

  localparam int REM_W = OUT_SIG_W + 2;
  localparam int CNT_W = $clog2(OUT_SIG_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                          state_q;
  logic [IN_SIG_W-1:0]             rad_q;
  logic [REM_W-1:0]                rem_q;
  logic [OUT_SIG_W-1:0]            root_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [OUT_EXP_W-1:0]            exp_q;
  logic                            sticky_q;
  logic                            out_valid_q;
  logic [OUT_EXP_W+OUT_SIG_W:0]    out_word_q;
  logic                            out_inexact_q;

  logic [IN_EXP_W-1:0]  in_exp;
  logic [IN_SIG_W-1:0]  in_sig;
  logic [IN_EXP_W:0]    exp_adj;
  logic [OUT_EXP_W-1:0] exp_cap;
  logic [IN_SIG_W-1:0]  rad_cap;

  // An odd exponent is made even by halving the radicand; the lost LSB becomes sticky.
  always_comb begin
    in_exp  = in_word[IN_EXP_W+IN_SIG_W-1:IN_SIG_W];
    in_sig  = in_word[IN_SIG_W-1:0];
    exp_adj = {1'b0, in_exp} + {{IN_EXP_W{1'b0}}, in_exp[0]};
    exp_cap = OUT_EXP_W'(exp_adj >> 1);
    rad_cap = in_exp[0] ? (in_sig >> 1) : in_sig;
  end

  logic [REM_W+1:0]     num;
  logic [REM_W+1:0]     sub;
  logic                 ge;
  logic [REM_W-1:0]     rem_d;
  logic [OUT_SIG_W-1:0] root_d;
  logic [OUT_SIG_W-1:0] root_fin;

  always_comb begin
    num    = {rem_q, rad_q[IN_SIG_W-1 -: 2]};
    sub    = {2'b00, root_q, 2'b01};
    ge     = (num >= sub);
    rem_d  = ge ? REM_W'(num - sub) : REM_W'(num);
    root_d = {root_q[OUT_SIG_W-2:0], ge};
    root_fin = root_d;
`ifdef SQRT_ROUND_EN
    // Round up when rem > root; an all-ones root stays put rather than wrapping.
    if ((rem_d >= REM_W'(root_d) + REM_W'(1)) && !(&root_d))
      root_fin = root_d + OUT_SIG_W'(1);
`endif
  end

  // FSM with every output registered in the same process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rad_q         <= '0;
      rem_q         <= '0;
      root_q        <= '0;
      cnt_q         <= '0;
      exp_q         <= '0;
      sticky_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_word_q    <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in_sig == '0) begin
              state_q       <= DONE;
              out_valid_q   <= 1'b1;
              out_word_q    <= '0;
              out_inexact_q <= 1'b0;
            end else begin
              state_q  <= CALC;
              rad_q    <= rad_cap;
              rem_q    <= '0;
              root_q   <= '0;
              cnt_q    <= '0;
              exp_q    <= exp_cap;
              sticky_q <= in_exp[0] & in_sig[0];
            end
          end
        end
        CALC: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          rad_q  <= rad_q << 2;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(OUT_SIG_W - 1)) begin
            state_q       <= DONE;
            out_valid_q   <= 1'b1;
            out_word_q    <= {1'b0, exp_q, root_fin};
            out_inexact_q <= sticky_q | (rem_d != '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign out_word    = out_word_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp_sqrt_unit.sv
// Self-checking bench for fp_sqrt_unit: directed vectors plus random operands against an integer-sqrt model.
module tb_fp_sqrt_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [38:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_word;
  logic        out_inexact;

  int checks = 0;
  int errors = 0;

  fp_sqrt_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  // Reference: floor sqrt by binary search, then optional round-to-nearest with saturation.
  function automatic void ref_sqrt(input logic [8:0] e, input logic [29:0] s,
                                   output logic [23:0] w, output logic inx);
    longint rad, lo, hi, mid, r, ex;
    if (s == 0) begin
      w = 24'h0; inx = 1'b0;
      return;
    end
    rad = (e % 2 == 1) ? longint'(s) / 2 : longint'(s);
    ex  = (e % 2 == 1) ? (longint'(e) + 1) / 2 : longint'(e) / 2;
    lo = 0; hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= rad) lo = mid; else hi = mid;
    end
    r = lo;
    inx = ((e % 2 == 1) && (s % 2 == 1)) || (r * r != rad);
`ifdef SQRT_ROUND_EN
    if (4 * rad >= (2 * r + 1) * (2 * r + 1)) r = r + 1;
    if (r > 32767) r = 32767;
`endif
    w = {1'b0, 8'(ex % 256), 15'(r)};
  endfunction

  task automatic run_op(input logic [8:0] e, input logic [29:0] s,
                        output logic [23:0] w, output logic inx, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk); guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    in_word  = {e, s};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk); lat++;
    end
    w   = out_word;
    inx = out_inexact;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_word !== 24'h0 || out_inexact !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%0b word=%h inexact=%0b required 0/000000/0",
               out_valid, out_word, out_inexact);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [8:0]  ev [5] = '{9'd4, 9'd3, 9'd3, 9'd0, 9'd0};
    logic [29:0] sv [5] = '{30'd144, 30'd50, 30'd51, 30'd7, 30'h3FFFFFFF};
    logic [23:0] wv [5];
    logic        iv [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [23:0] w;
    logic        inx;
    int          lat;
    wv[0] = 24'h01000C; wv[1] = 24'h010005; wv[2] = 24'h010005; wv[4] = 24'h007FFF;
`ifdef SQRT_ROUND_EN
    wv[3] = 24'h000003;
`else
    wv[3] = 24'h000002;
`endif
    for (int i = 0; i < 5; i++) begin
      run_op(ev[i], sv[i], w, inx, lat);
      checks++;
      if (w !== wv[i] || inx !== iv[i] || lat != 16) begin
        errors++;
        $display("[TB] FAIL directed_%0d: word=%h inexact=%0b lat=%0d required %h/%0b/16",
                 i, w, inx, lat, wv[i], iv[i]);
      end
      finish_op();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL directed_release_%0d: valid=%0b in_ready=%0b required 0/1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_zero();
    logic [23:0] w;
    logic        inx;
    int          lat;
    run_op(9'd7, 30'd0, w, inx, lat);
    checks++;
    if (w !== 24'h0 || inx !== 1'b0 || lat != 1) begin
      errors++;
      $display("[TB] FAIL zero_sig: word=%h inexact=%0b lat=%0d required 000000/0/1", w, inx, lat);
    end
    finish_op();
  endtask

  task automatic test_backpressure();
    logic [23:0] w, we;
    logic        inx, ie;
    int          lat;
    ref_sqrt(9'd11, 30'd123457, we, ie);
    run_op(9'd11, 30'd123457, w, inx, lat);
    for (int c = 0; c < 5; c++) begin
      in_word  = {9'd2, 30'($urandom())};
      in_valid = c[0];
      @(negedge clk);
      checks++;
      if (out_word !== we || out_inexact !== ie || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure_%0d: word=%h inexact=%0b valid=%0b in_ready=%0b required %h/%0b/1/0",
                 c, out_word, out_inexact, out_valid, in_ready, we, ie);
      end
    end
    in_valid = 1'b0;
    finish_op();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_release: valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignored_pulses: valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_reset_abort();
    logic [23:0] w, we;
    logic        inx, ie;
    int          lat;
    in_word  = {9'd6, 30'd999999};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_word !== 24'h0 || out_inexact !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_calc: valid=%0b word=%h inexact=%0b required 0/000000/0",
               out_valid, out_word, out_inexact);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_recover: in_ready=%0b valid=%0b required 1/0", in_ready, out_valid);
    end
    run_op(9'd5, 30'd80000, w, inx, lat);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_word !== 24'h0) begin
      errors++;
      $display("[TB] FAIL abort_done: valid=%0b word=%h required 0/000000", out_valid, out_word);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ref_sqrt(9'd8, 30'd1000000, we, ie);
    run_op(9'd8, 30'd1000000, w, inx, lat);
    checks++;
    if (w !== we || inx !== ie || lat != 16) begin
      errors++;
      $display("[TB] FAIL abort_fresh_op: word=%h inexact=%0b lat=%0d required %h/%0b/16", w, inx, lat, we, ie);
    end
    finish_op();
  endtask

  task automatic test_random();
    logic [8:0]  e;
    logic [29:0] s;
    logic [23:0] w, we;
    logic        inx, ie;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      e = 9'($urandom_range(0, 509));
      if (i % 8 == 1)      s = 30'd0;
      else if (i % 4 == 0) s = 30'($urandom_range(1, 300));
      else                 s = 30'($urandom());
      ref_sqrt(e, s, we, ie);
      run_op(e, s, w, inx, lat);
      checks++;
      if (w !== we || inx !== ie || lat != ((s == 0) ? 1 : 16)) begin
        errors++;
        $display("[TB] FAIL random_%0d exp=%0d sig=%h: word=%h inexact=%0b lat=%0d required %h/%0b",
                 i, e, s, w, inx, lat, we, ie);
      end
      finish_op();
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  e;
    logic [29:0] s;
    logic [23:0] w, we;
    logic        inx, ie;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      e = 9'($urandom_range(0, 509));
      s = 30'($urandom());
      ref_sqrt(e, s, we, ie);
      run_op(e, s, w, inx, lat);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (w !== we || inx !== ie || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: word=%h inexact=%0b in_ready=%0b required %h/%0b/1",
                 i, w, inx, in_ready, we, ie);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_backpressure();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
